// File: rtl/blink_defs.sv
// ---------------------------------------------------------------------------
// blink_defs
//
// Shared definitions for the LED blink path that sits after the button/event
// conditioning logic.
//
// Contents:
//   blink_state_e   - encoding of the blinker FSM states (IDLE / ON / GAP)
//   CLK_HZ          - fabric clock frequency (clk_20)
//   LED_HOLD_100MS  - clk_20 cycles in a 100 ms LED ON window
//   LED_GAP_50MS    - clk_20 cycles in a 50 ms forced OFF gap
//   pend_full       - helper that tells whether a pending count is saturated
// ---------------------------------------------------------------------------
package blink_defs;

  // The encodings are fixed so that the state can be recognised directly on
  // a logic analyser probe of the state register.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } blink_state_e;

  // Fabric clock and the human-visible timing derived from it.
  localparam int CLK_HZ         = 20000000;
  localparam int LED_HOLD_100MS = CLK_HZ / 10;
  localparam int LED_GAP_50MS   = CLK_HZ / 20;

  // A pending counter is full once it reaches the configured limit; any
  // further event at that point has to be dropped.
  function automatic logic pend_full(input int unsigned count,
                                     input int unsigned limit);
    return (count >= limit);
  endfunction

endpackage : blink_defs

// File: rtl/pulse_blinker_cycle_timer.sv
// ---------------------------------------------------------------------------
// cycle_timer
//
// Loadable down-counter shared by the ON window and the OFF gap of the
// blinker. A load takes priority over counting. Once the counter reaches zero
// it holds there until loaded again, so an idle timer reads as done.
//
// Ports:
//   clk_i       - clock, rising edge
//   rst_i       - asynchronous active-high reset (counter cleared to 0)
//   load_i      - load load_val_i on the next edge
//   load_val_i  - value to load (cycles remaining minus one)
//   done_o      - high while the counter value is zero
// ---------------------------------------------------------------------------
module cycle_timer #(
  parameter int CNT_W = 21
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             done_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: a load wins, otherwise step down and stick at zero so the
  // timer never wraps while the FSM is parked in IDLE.
  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register, cleared by the asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign done_o = (count_q == '0);

endmodule : cycle_timer

// File: rtl/pulse_blinker.sv
// ---------------------------------------------------------------------------
// pulse_blinker
//
// Turns single-cycle event strobes on clk_20 into human-visible LED blinks.
// Each accepted event gives one ON window of HOLD_CYCLES followed by a forced
// OFF gap of GAP_CYCLES. Events arriving while a blink is running are counted
// (up to MAX_PENDING) and replayed one after another; events beyond that
// limit are dropped and flagged on the sticky overflow output.
//
// Ports:
//   clk_20    - 20 MHz fabric clock, rising edge
//   rst       - asynchronous active-high reset; aborts any blink and empties
//               the queue
//   pulse_in  - event strobe, every high cycle is one event
//   clr_ovf   - synchronous clear of the overflow flag (a drop in the same
//               cycle wins)
//   led       - registered LED drive, 1 = ON
//   busy      - registered, high whenever the FSM is not IDLE
//   pending   - registered count of queued events
//   overflow  - sticky flag, set when an event is dropped at saturation
//
// All outputs come straight from registers; no input reaches an output
// without passing through a flop.
// ---------------------------------------------------------------------------
module pulse_blinker
  import blink_defs::*;
#(
  parameter int HOLD_CYCLES = LED_HOLD_100MS,
  parameter int GAP_CYCLES  = LED_GAP_50MS,
  parameter int MAX_PENDING = 7,
  parameter int CNT_W       = 21,
  parameter int PEND_W      = 3
) (
  input  logic              clk_20,
  input  logic              rst,
  input  logic              pulse_in,
  input  logic              clr_ovf,
  output logic              led,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow
);

  // Timer reload values: the timer counts down to zero inclusive, so a
  // window of N cycles is loaded with N-1.
  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PENDING);

  blink_state_e      state_q;
  logic              led_q;
  logic              busy_q;
  logic [PEND_W-1:0] pending_q;
  logic [PEND_W-1:0] pending_d;
  logic              overflow_q;
  logic              overflow_d;

  logic              timerDone;
  logic              timerLoad;
  logic [CNT_W-1:0]  timerLoadVal;
  logic              finalGap;
  logic              enqueue;
  logic              drop;
  logic              restart;

  // -------------------------------------------------------------------------
  // Shared cycle timer for both the ON window and the OFF gap.
  // -------------------------------------------------------------------------
  cycle_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk_i      (clk_20),
    .rst_i      (rst),
    .load_i     (timerLoad),
    .load_val_i (timerLoadVal),
    .done_o     (timerDone)
  );

  // Event classification for the current cycle. The last GAP cycle is the
  // hand-over point: an event there either starts the next blink directly
  // (queue empty) or cancels against the queued event being consumed, so it
  // is never counted as a new queue entry. Everywhere else in ON/GAP
  // (including the last ON cycle) an event is queued, or dropped when the
  // queue is already full.
  always_comb begin
    finalGap = (state_q == ST_GAP) && timerDone;
    restart  = finalGap && ((pending_q != '0) || pulse_in);
    enqueue  = pulse_in &&
               ((state_q == ST_ON) || ((state_q == ST_GAP) && !timerDone));
    drop     = enqueue && pend_full(int'(pending_q), int'(PEND_MAX));
  end

  // Timer control: reload for a fresh ON window when a blink starts from
  // IDLE or restarts out of GAP, and reload for the OFF gap when ON expires.
  always_comb begin
    timerLoad    = 1'b0;
    timerLoadVal = HOLD_LOAD;
    if ((state_q == ST_IDLE) && pulse_in) begin
      timerLoad    = 1'b1;
      timerLoadVal = HOLD_LOAD;
    end else if ((state_q == ST_ON) && timerDone) begin
      timerLoad    = 1'b1;
      timerLoadVal = GAP_LOAD;
    end else if (restart) begin
      timerLoad    = 1'b1;
      timerLoadVal = HOLD_LOAD;
    end
  end

  // Pending queue and overflow next-state. Leaving GAP for a replay consumes
  // one queued event unless a fresh event arrives in that same cycle, in
  // which case the two cancel and the count is unchanged.
  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;

    if (enqueue && !drop) begin
      pending_d = pending_q + 1'b1;
    end else if (finalGap && (pending_q != '0) && !pulse_in) begin
      pending_d = pending_q - 1'b1;
    end

    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  // Blink FSM with registered LED and busy outputs.
  always_ff @(posedge clk_20 or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pulse_in) begin
            state_q <= ST_ON;
            led_q   <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_ON: begin
          if (timerDone) begin
            state_q <= ST_GAP;
            led_q   <= 1'b0;
          end
        end
        ST_GAP: begin
          if (timerDone) begin
            if (restart) begin
              state_q <= ST_ON;
              led_q   <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          led_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Queue depth and sticky overflow registers.
  always_ff @(posedge clk_20 or posedge rst) begin
    if (rst) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign led      = led_q;
  assign busy     = busy_q;
  assign pending  = pending_q;
  assign overflow = overflow_q;

endmodule : pulse_blinker

// File: tb/tb_pulse_blinker.sv
// ---------------------------------------------------------------------------
// tb_pulse_blinker
//
// Directed bench for pulse_blinker with short timing (HOLD=4, GAP=3,
// MAX_PENDING=2). Edges are numbered from the first clk_20 rising edge after
// reset release; "event at edge N" means pulse_in is high when edge N samples
// it, and outputs are observed 1 ns after the edge.
// ---------------------------------------------------------------------------
module tb_pulse_blinker;

  localparam int HOLD = 4;
  localparam int GAP  = 3;
  localparam int MAXP = 2;
  localparam int PW   = 2;
  localparam int CW   = 3;

  logic          clk_20 = 1'b0;
  logic          rst;
  logic          pulse_in;
  logic          clr_ovf;
  logic          led;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;

  int testCount = 0;
  int failCount = 0;
  int edgeNo    = 0;

  pulse_blinker #(
    .HOLD_CYCLES (HOLD),
    .GAP_CYCLES  (GAP),
    .MAX_PENDING (MAXP),
    .CNT_W       (CW),
    .PEND_W      (PW)
  ) dut (
    .clk_20   (clk_20),
    .rst      (rst),
    .pulse_in (pulse_in),
    .clr_ovf  (clr_ovf),
    .led      (led),
    .busy     (busy),
    .pending  (pending),
    .overflow (overflow)
  );

  // 20 MHz clock.
  always #25 clk_20 = ~clk_20;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input int actual, input int expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, want %0d (edge %0d)", tag, actual, expected, edgeNo);
    end
  endtask

  // Advance to 1 ns after edge n.
  task automatic goEdge(input int n);
    bit moved;
    moved = 1'b0;
    while (edgeNo < n) begin
      @(posedge clk_20);
      edgeNo++;
      moved = 1'b1;
    end
    if (moved) #1;
  endtask

  // Set the inputs so that they are sampled by edge atEdge.
  task automatic applyStimulus(input int atEdge, input logic p, input logic c);
    goEdge(atEdge - 1);
    pulse_in = p;
    clr_ovf  = c;
  endtask

  // Synchronous-looking reset pulse and edge counter restart.
  task automatic startTest();
    rst      = 1'b1;
    pulse_in = 1'b0;
    clr_ovf  = 1'b0;
    @(posedge clk_20);
    #1;
    rst    = 1'b0;
    edgeNo = 0;
  endtask

  // Status check helper used by the scenario blocks.
  task automatic checkState(input string tag, input int expLed, input int expBusy,
                            input int expPend, input int expOvf);
    checkOutput({tag, ".led"},      32'(led),      expLed);
    checkOutput({tag, ".busy"},     32'(busy),     expBusy);
    checkOutput({tag, ".pending"},  32'(pending),  expPend);
    checkOutput({tag, ".overflow"}, 32'(overflow), expOvf);
  endtask

  initial begin
    int starts;
    int startEdge [3];
    logic prevLed;

    // ---------------- Single blink ----------------
    startTest();
    checkState("reset", 0, 0, 0, 0);
    applyStimulus(10, 1'b1, 1'b0);
    applyStimulus(11, 1'b0, 1'b0);
    checkState("single@10", 1, 1, 0, 0);
    for (int e = 11; e <= 20; e++) begin
      goEdge(e);
      checkOutput("single.led",  32'(led),  (e <= 13) ? 1 : 0);
      checkOutput("single.busy", 32'(busy), (e <= 16) ? 1 : 0);
      checkOutput("single.pend", 32'(pending), 0);
    end

    // ---------------- Queued replay ----------------
    startTest();
    applyStimulus(10, 1'b1, 1'b0);
    applyStimulus(11, 1'b0, 1'b0);
    applyStimulus(12, 1'b1, 1'b0);
    applyStimulus(13, 1'b0, 1'b0);
    checkOutput("queue.pend@12", 32'(pending), 1);
    for (int e = 13; e <= 25; e++) begin
      goEdge(e);
      checkOutput("queue.led", 32'(led),
                  ((e <= 13) || (e >= 17 && e <= 20)) ? 1 : 0);
      checkOutput("queue.busy", 32'(busy), (e <= 23) ? 1 : 0);
      if (e == 16) checkOutput("queue.pend@16", 32'(pending), 1);
      if (e == 17) checkOutput("queue.pend@17", 32'(pending), 0);
    end

    // ---------------- Saturation ----------------
    startTest();
    applyStimulus(10, 1'b1, 1'b0);
    prevLed = 1'b0;
    starts  = 0;
    for (int e = 10; e <= 32; e++) begin
      goEdge(e);
      if (e == 13) pulse_in = 1'b0;
      if (led && !prevLed) begin
        if (starts < 3) startEdge[starts] = e;
        starts++;
      end
      prevLed = led;
      if (e == 12) begin
        checkOutput("sat.pend@12", 32'(pending), 2);
        checkOutput("sat.ovf@12",  32'(overflow), 0);
      end
      if (e == 13) begin
        checkOutput("sat.pend@13", 32'(pending), 2);
        checkOutput("sat.ovf@13",  32'(overflow), 1);
      end
      if (e == 17) checkOutput("sat.pend@17", 32'(pending), 1);
      if (e == 24) checkOutput("sat.pend@24", 32'(pending), 0);
      if (e == 31) checkOutput("sat.busy@31", 32'(busy), 0);
    end
    checkOutput("sat.blinks", starts, 3);
    if (starts >= 3) begin
      checkOutput("sat.start0", startEdge[0], 10);
      checkOutput("sat.start1", startEdge[1], 17);
      checkOutput("sat.start2", startEdge[2], 24);
    end
    checkOutput("sat.ovfSticky", 32'(overflow), 1);
    // Overflow clear on its own.
    applyStimulus(33, 1'b0, 1'b1);
    applyStimulus(34, 1'b0, 1'b0);
    checkOutput("clr.alone", 32'(overflow), 0);

    // ---------------- Clear collides with a drop ----------------
    startTest();
    applyStimulus(10, 1'b1, 1'b0);
    applyStimulus(13, 1'b1, 1'b1);
    checkOutput("clrdrop.ovf@12", 32'(overflow), 0);
    checkOutput("clrdrop.pend@12", 32'(pending), 2);
    applyStimulus(14, 1'b0, 1'b1);
    checkOutput("clrdrop.setWins", 32'(overflow), 1);
    applyStimulus(15, 1'b0, 1'b0);
    checkOutput("clrdrop.cleared", 32'(overflow), 0);
    checkOutput("clrdrop.pend@14", 32'(pending), 2);

    // ---------------- Boundary cancel, pending=1 ----------------
    startTest();
    applyStimulus(10, 1'b1, 1'b0);
    applyStimulus(11, 1'b0, 1'b0);
    applyStimulus(12, 1'b1, 1'b0);
    applyStimulus(13, 1'b0, 1'b0);
    applyStimulus(17, 1'b1, 1'b0);
    checkState("cancel@16", 0, 1, 1, 0);
    applyStimulus(18, 1'b0, 1'b0);
    checkState("cancel@17", 1, 1, 1, 0);
    goEdge(21);
    checkState("cancel@21", 0, 1, 1, 0);
    goEdge(24);
    checkState("cancel@24", 1, 1, 0, 0);
    goEdge(31);
    checkState("cancel@31", 0, 0, 0, 0);

    // ---------------- Direct consume at final GAP, pending=0 ----------------
    startTest();
    applyStimulus(10, 1'b1, 1'b0);
    applyStimulus(11, 1'b0, 1'b0);
    applyStimulus(17, 1'b1, 1'b0);
    checkState("direct@16", 0, 1, 0, 0);
    applyStimulus(18, 1'b0, 1'b0);
    checkState("direct@17", 1, 1, 0, 0);
    goEdge(20);
    checkOutput("direct.led@20", 32'(led), 1);
    goEdge(21);
    checkOutput("direct.led@21", 32'(led), 0);

    // ---------------- Asynchronous reset mid-ON ----------------
    startTest();
    applyStimulus(10, 1'b1, 1'b0);
    applyStimulus(12, 1'b0, 1'b0);
    checkState("arst@11", 1, 1, 1, 0);
    goEdge(12);
    #1;
    rst = 1'b1;
    #1;
    checkState("arst.during", 0, 0, 0, 0);
    #5;
    rst = 1'b0;
    applyStimulus(30, 1'b1, 1'b0);
    checkState("arst@29", 0, 0, 0, 0);
    applyStimulus(31, 1'b0, 1'b0);
    checkState("arst@30", 1, 1, 0, 0);
    for (int e = 31; e <= 35; e++) begin
      goEdge(e);
      checkOutput("arst.led", 32'(led), (e <= 33) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", testCount, failCount);
    $finish;
  end

endmodule : tb_pulse_blinker
